// File: rtl/evm_result_reader.sv
// evm_result_reader: steps the EVM through candidates 1..3, captures counts,
// picks the winner and streams A5,c1,c2,c3,W over an 8N1 UART.
module evm_result_reader #(
    parameter int CLKS_PER_BIT  = 104,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       voting_done,
    input  logic       invalid_results,
    input  logic [6:0] results,
    output logic [1:0] display_results,
    output logic       tx,
    output logic       busy,
    output logic [1:0] winner,
    output logic       winner_valid,
    output logic       done
);
    typedef enum logic [3:0] {IDLE, SEL1, SEL2, SEL3, TX_HDR, TX_C1, TX_C2, TX_C3, TX_WIN} state_t;
    localparam int CMAX = CLKS_PER_BIT > SETTLE_CYCLES + 2 ? CLKS_PER_BIT : SETTLE_CYCLES + 2;
    localparam int CW = $clog2(CMAX);

    state_t state, state_n, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] bit_idx, bit_idx_n;
    logic [8:0] sh, sh_n;
    logic [6:0] c1, c2, c3, c1_n, c2_n, c3_n;
    logic inv, inv_n, tx_n, busy_n, winner_valid_n, done_n;
    logic [1:0] disp_n, winner_n;
    logic [7:0] w_byte, nbyte;

    assign w_byte = inv ? 8'hFF :
                    (c1 > c2 && c1 > c3) ? 8'h01 :
                    (c2 > c1 && c2 > c3) ? 8'h02 :
                    (c3 > c1 && c3 > c2) ? 8'h03 : 8'h00;

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        bit_idx_n      = bit_idx;
        sh_n           = sh;
        c1_n           = c1;
        c2_n           = c2;
        c3_n           = c3;
        inv_n          = inv;
        tx_n           = tx;
        busy_n         = busy;
        disp_n         = display_results;
        winner_n       = winner;
        winner_valid_n = winner_valid;
        done_n         = 1'b0;
        nxt            = state_t'(state + 4'd1);
        nbyte          = nxt == TX_C1 ? {1'b0, c1} :
                         nxt == TX_C2 ? {1'b0, c2} :
                         nxt == TX_C3 ? {1'b0, c3} : w_byte;
        case (state)
            IDLE: begin
                if (start && voting_done) begin
                    state_n        = SEL1;
                    cnt_n          = '0;
                    busy_n         = 1'b1;
                    disp_n         = 2'd1;
                    winner_n       = 2'd0;
                    winner_valid_n = 1'b0;
                    inv_n          = 1'b0;
                end
            end
            SEL1, SEL2, SEL3: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(SETTLE_CYCLES)) begin
                    c1_n  = state == SEL1 ? results : c1;
                    c2_n  = state == SEL2 ? results : c2;
                    c3_n  = state == SEL3 ? results : c3;
                    inv_n = inv | invalid_results;
                    if (state == SEL3) disp_n = 2'd0;
                    else begin
                        state_n = nxt;
                        cnt_n   = '0;
                        disp_n  = display_results + 2'd1;
                    end
                end
                // one spare cycle after the last capture lets the winner settle before the header
                if (state == SEL3 && cnt == CW'(SETTLE_CYCLES + 1)) begin
                    state_n        = TX_HDR;
                    cnt_n          = '0;
                    bit_idx_n      = '0;
                    tx_n           = 1'b0;
                    sh_n           = {1'b1, 8'hA5};
                    winner_n       = w_byte inside {8'h01, 8'h02, 8'h03} ? w_byte[1:0] : 2'd0;
                    winner_valid_n = w_byte inside {8'h01, 8'h02, 8'h03};
                end
            end
            default: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n = '0;
                    if (bit_idx == 4'd9) begin
                        if (state == TX_WIN) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            tx_n    = 1'b1;
                        end else begin
                            state_n   = nxt;
                            tx_n      = 1'b0;
                            sh_n      = {1'b1, nbyte};
                            bit_idx_n = '0;
                        end
                    end else begin
                        tx_n      = sh[0];
                        sh_n      = {1'b0, sh[8:1]};
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end else cnt_n = cnt + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            sh              <= '1;
            c1              <= '0;
            c2              <= '0;
            c3              <= '0;
            inv             <= 1'b0;
            tx              <= 1'b1;
            busy            <= 1'b0;
            display_results <= 2'd0;
            winner          <= 2'd0;
            winner_valid    <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            bit_idx         <= bit_idx_n;
            sh              <= sh_n;
            c1              <= c1_n;
            c2              <= c2_n;
            c3              <= c3_n;
            inv             <= inv_n;
            tx              <= tx_n;
            busy            <= busy_n;
            display_results <= disp_n;
            winner          <= winner_n;
            winner_valid    <= winner_valid_n;
            done            <= done_n;
        end
    end
endmodule
